// File: rtl/im_loader.sv
// Boot loader for s_cycle_cpu: takes a length-prefixed, XOR-checksummed byte stream,
// writes big-endian 32-bit words into instruction memory, and releases cpu_reset once verified.
module im_loader #(
  parameter int IM_DEPTH = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [23:0]       asm_q;

  logic        accept;
  logic        loading;
  logic [15:0] len_in;
  logic        last_word;
  logic        restart;

  assign loading   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CSUM);
  // Gated with reset so the upstream sees no ready while the loader is held.
  assign in_ready  = reset && loading;
  assign accept    = in_valid && in_ready;
  assign len_in    = {len_hi, in_data};
  assign last_word = (16'(word_idx) == (len - 16'd1));
  assign restart   = reload && ((state == S_DONE) || (state == S_ERR));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_LEN_HI;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LEN_HI: if (accept) state_nx = S_LEN_LO;
      S_LEN_LO: if (accept) begin
        if (len_in == 16'd0)                state_nx = S_CSUM;
        else if (len_in > 16'(IM_DEPTH))    state_nx = S_ERR;
        else                                state_nx = S_DATA;
      end
      S_DATA:   if (accept && byte_cnt == 2'd3 && last_word) state_nx = S_CSUM;
      S_CSUM:   if (accept) state_nx = (in_data == csum) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:    if (reload) state_nx = S_LEN_HI;
      default:  state_nx = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_hi    <= '0;
      len       <= '0;
      csum      <= '0;
      byte_cnt  <= '0;
      word_idx  <= '0;
      asm_q     <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      cpu_reset <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (accept && state != S_CSUM) csum <= csum ^ in_data;
      if (accept) begin
        case (state)
          S_LEN_HI: len_hi <= in_data;
          S_LEN_LO: len    <= len_in;
          S_DATA: begin
            asm_q    <= {asm_q[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_we    <= 1'b1;
              im_wdata <= {asm_q, in_data};
              im_addr  <= word_idx;
              word_idx <= word_idx + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
      if (state != S_DONE && state_nx == S_DONE) begin
        done      <= 1'b1;
        cpu_reset <= 1'b1;
      end
      if (state != S_ERR && state_nx == S_ERR) error <= 1'b1;
      // Memory is left as-is on restart; the next image overwrites from address 0.
      if (restart) begin
        done      <= 1'b0;
        error     <= 1'b0;
        cpu_reset <= 1'b0;
        csum      <= '0;
        len       <= '0;
        len_hi    <= '0;
        byte_cnt  <= '0;
        word_idx  <= '0;
        im_addr   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: per-cycle vector table plus hand sequences
// for stalled streaming and reset in the middle of a load.
module tb_im_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_reset, done, error;

  im_loader #(.IM_DEPTH(1024), .ADDR_W(10)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [41:0] wq[$];
  int          width_bad = 0;
  logic        prev_we = 1'b0;

  // Write log, sampled just after each edge; flags any im_we wider than one cycle.
  always @(posedge clock) begin
    #1;
    if (im_we) wq.push_back({im_addr, im_wdata});
    if (im_we && prev_we) width_bad++;
    prev_we = im_we;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rl, input logic rdy,
                     input logic we, input logic [9:0] addr, input logic [31:0] wd,
                     input logic dn, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.rl = rl; t.rdy = rdy; t.we = we;
    t.addr = addr; t.wd = wd; t.dn = dn; t.er = er;
    tbl.push_back(t);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      in_valid = 1'b0;
      reload   = 1'b0;
    end
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    in_valid = 1'b0;
    reload   = 1'b1;
    @(negedge clock);
    reload   = 1'b0;
  endtask

  logic [7:0] img[11];

  initial begin
    img = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04, 8'hAC};

    // Nominal image: writes after bytes 6 and 10, done after the checksum.
    for (int i = 0; i < 11; i++) begin
      if (i == 5)       add(1, img[i], 0, 1, 1, 10'd0, 32'h20010005, 0, 0);
      else if (i == 9)  add(1, img[i], 0, 1, 1, 10'd1, 32'h8C020004, 0, 0);
      else if (i == 10) add(1, img[i], 0, 0, 0, 10'd0, 32'h0, 1, 0);
      else              add(1, img[i], 0, 1, 0, 10'd0, 32'h0, 0, 0);
    end
    add(1, 8'hFF, 0, 0, 0, 10'd0, 32'h0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 10'd0, 32'h0, 0, 0);
    // Same image with a wrong checksum byte.
    for (int i = 0; i < 11; i++) begin
      if (i == 5)       add(1, img[i], 0, 1, 1, 10'd0, 32'h20010005, 0, 0);
      else if (i == 9)  add(1, img[i], 0, 1, 1, 10'd1, 32'h8C020004, 0, 0);
      else if (i == 10) add(1, 8'hAD, 0, 0, 0, 10'd0, 32'h0, 0, 1);
      else              add(1, img[i], 0, 1, 0, 10'd0, 32'h0, 0, 0);
    end
    add(0, 8'h00, 0, 0, 0, 10'd0, 32'h0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 10'd0, 32'h0, 0, 0);
    // Length 0x0401 = 1025 exceeds the memory.
    add(1, 8'h04, 0, 1, 0, 10'd0, 32'h0, 0, 0);
    add(1, 8'h01, 0, 0, 0, 10'd0, 32'h0, 0, 1);
    add(1, 8'h00, 0, 0, 0, 10'd0, 32'h0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 10'd0, 32'h0, 0, 0);
    // Zero-length image, good and bad checksum.
    add(1, 8'h00, 0, 1, 0, 10'd0, 32'h0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 10'd0, 32'h0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 10'd0, 32'h0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 10'd0, 32'h0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 10'd0, 32'h0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 10'd0, 32'h0, 0, 0);
    add(1, 8'h01, 0, 0, 0, 10'd0, 32'h0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 10'd0, 32'h0, 0, 0);

    #2;
    check("rst_ready", in_ready, 0);
    check("rst_we",    im_we,    0);
    check("rst_addr",  im_addr,  0);
    check("rst_wdata", im_wdata, 0);
    check("rst_done",  done,     0);
    check("rst_err",   error,    0);
    check("rst_cpu",   cpu_reset, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clock);
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      reload   = tbl[i].rl;
      @(posedge clock);
      #1;
      check($sformatf("v%0d_ready", i), in_ready,  tbl[i].rdy);
      check($sformatf("v%0d_we",    i), im_we,     tbl[i].we);
      check($sformatf("v%0d_done",  i), done,      tbl[i].dn);
      check($sformatf("v%0d_err",   i), error,     tbl[i].er);
      check($sformatf("v%0d_cpu",   i), cpu_reset, tbl[i].dn);
      if (tbl[i].we) begin
        check($sformatf("v%0d_addr",  i), im_addr,  tbl[i].addr);
        check($sformatf("v%0d_wdata", i), im_wdata, tbl[i].wd);
      end
    end
    idle(1);

    // Stalled stream: 3 idle cycles after every second byte.
    wq.delete();
    width_bad = 0;
    for (int i = 0; i < 11; i++) begin
      send(img[i]);
      if (i % 2 == 1) idle(3);
    end
    idle(2);
    check("stall_nwr",   wq.size(), 2);
    if (wq.size() == 2) begin
      check("stall_w0_addr", wq[0][41:32], 10'd0);
      check("stall_w0_data", wq[0][31:0],  32'h20010005);
      check("stall_w1_addr", wq[1][41:32], 10'd1);
      check("stall_w1_data", wq[1][31:0],  32'h8C020004);
    end
    check("stall_width", width_bad, 0);
    check("stall_done",  done,      1);
    check("stall_cpu",   cpu_reset, 1);
    check("stall_ready", in_ready,  0);
    pulse_reload();

    // Reset after five payload bytes, then a clean reload of the nominal image.
    for (int i = 0; i < 7; i++) send(img[i]);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_ready", in_ready,  0);
    check("mid_we",    im_we,     0);
    check("mid_addr",  im_addr,   0);
    check("mid_wdata", im_wdata,  0);
    check("mid_done",  done,      0);
    check("mid_err",   error,     0);
    check("mid_cpu",   cpu_reset, 0);
    @(negedge clock);
    reset = 1'b1;
    wq.delete();
    for (int i = 0; i < 11; i++) send(img[i]);
    idle(2);
    check("re_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      check("re_w0_addr", wq[0][41:32], 10'd0);
      check("re_w0_data", wq[0][31:0],  32'h20010005);
      check("re_w1_addr", wq[1][41:32], 10'd1);
      check("re_w1_data", wq[1][31:0],  32'h8C020004);
    end
    check("re_done", done,  1);
    check("re_err",  error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
